token_slot_sched: RTL and testbench
===================================

Name: token_slot_sched

Overview:
- Generates the token-ring slot timebase consumed by main_ctrl: per-slot start strobe `flag_slot_start` and slot index `id_slot`, cycling 0..MAX_ID_SLOT.
- Two ways to start:
  - As master, on `flag_start_token`.
  - As joiner, by locking to sync frames received from the bus.
- Opens this board's transmit window in its own slot.
- Sits between main_ctrl and the bus tx/rx framers.

Parameters:
- SLOT_LEN, 500: clocks per slot, ≥ 2*GUARD+2.
- MAX_ID_SLOT, 71: last slot index, 8-bit.
- GUARD, 16: clocks masked at each slot edge for tx window.
- SYNC_TIMEOUT, 200000: clocks allowed in WAIT_SYNC before failing.
- TOL, 8: accepted |slot_cnt| phase error for a realign.
- MAX_ERR, 3: consecutive mismatched syncs before dropping lock.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, asynchronous, active-low.
- process_en, in, 1: enable from main_ctrl; 0 forces IDLE.
- flag_start_token, in, 1: one-cycle master-start strobe.
- join_start, in, 1: 1 = start by joining an existing ring.
- slot_id, in, 4: board slot; own slot index = {4'b0, slot_id}.
- rx_sync_vld, in, 1: one-cycle valid sync frame received.
- rx_sync_slot, in, 8: slot index carried in the sync frame.
- flag_slot_start, out, 1: one-cycle strobe, first clock of each slot.
- id_slot, out, 8: current slot index, valid with and after the strobe.
- tx_win, out, 1: own-slot transmit window.
- locked, out, 1: 1 in RUN.
- sync_fail, out, 1: one-cycle pulse on WAIT_SYNC timeout.
- err_cnt, out, 2: consecutive sync-mismatch count.

Behaviour:
- Reset (rst=0, async): state=IDLE; every output 0; slot_cnt=0; timeout counter=0.
- States: IDLE, WAIT_SYNC, RUN. All outputs registered.
- IDLE:
  - process_en=1 and flag_start_token=1 → RUN; next cycle id_slot=0, flag_slot_start=1, slot_cnt=0.
  - Else process_en=1 and join_start=1 → WAIT_SYNC; timeout counter cleared.
- WAIT_SYNC:
  - rx_sync_vld=1 and rx_sync_slot ≤ MAX_ID_SLOT → RUN; next cycle id_slot=rx_sync_slot, flag_slot_start=1, slot_cnt=0.
  - rx_sync_slot > MAX_ID_SLOT: ignored.
  - flag_start_token=1: treated as master start, with priority over rx_sync_vld in the same cycle.
  - Timeout counter reaches SYNC_TIMEOUT-1 → sync_fail=1 for one cycle, state → IDLE.
- RUN:
  - slot_cnt counts 0..SLOT_LEN-1.
  - At SLOT_LEN-1: slot_cnt→0; id_slot+1, wrapping MAX_ID_SLOT→0; flag_slot_start=1 for exactly one cycle.
  - rx_sync_vld with rx_sync_slot==id_slot and (slot_cnt ≤ TOL or slot_cnt ≥ SLOT_LEN-TOL):
    - slot_cnt realigned to 1 the next cycle; no extra strobe.
    - If slot_cnt ≥ SLOT_LEN-TOL, id_slot is not advanced, since the sync marks the current slot start.
    - err_cnt cleared.
  - rx_sync_vld otherwise: err_cnt+1, saturating.
    - The mismatch that makes the count MAX_ERR → WAIT_SYNC, err_cnt cleared.
  - flag_start_token=1 in RUN restarts at slot 0 (strobe, slot_cnt=0). It overrides rx_sync_vld and a natural wrap in the same cycle.
- tx_win = locked and id_slot == own slot and GUARD ≤ slot_cnt ≤ SLOT_LEN-GUARD-1. Registered, one cycle latency vs slot_cnt.
- process_en=0 in any state: next cycle IDLE with all outputs 0. This includes mid-slot and mid-window, where tx_win drops within 1 cycle.
- Own slot > MAX_ID_SLOT: tx_win never asserts.
- Widths: slot_cnt and timeout counter are sized by $clog2 of their parameter. No overflow is possible.

Decomposition:
- Shared package holds:
  - State encoding: IDLE, WAIT_SYNC, RUN.
  - MAX_ID_SLOT.
  - Slot defaults SLOT_LEN and GUARD.
  - The 8-bit slot-index type used by main_ctrl and the framers.
- One natural sub-module: `slot_timer`, holding slot_cnt plus id_slot with wrap, load and realign inputs. The FSM stays in the top.

Test Plan:
- Master start: process_en=1, flag_start_token pulse, SLOT_LEN=20, MAX_ID_SLOT=3 → strobes every 20 clks, id_slot 0,1,2,3,0; locked=1.
- Join: join_start=1, rx_sync_vld with slot 5 → next cycle id_slot=5 and strobe. Then rx_sync_slot=200 sent in WAIT_SYNC on a fresh run → ignored.
- Timeout: join_start=1, no sync, SYNC_TIMEOUT=50 → sync_fail pulse at clk 50, state IDLE, all outputs 0.
- Drift/errors:
  - Matching sync at slot_cnt=SLOT_LEN-3 → realign, no double strobe.
  - 3 mismatched syncs → locked=0, WAIT_SYNC.
- tx window: slot_id=2, GUARD=4, SLOT_LEN=20 → tx_win high slot_cnt 4..15 of slot 2 only. process_en dropped at slot_cnt 8 → tx_win 0 the next cycle.
- Async reset asserted mid-RUN between clock edges → outputs 0 immediately. Release then IDLE, with no strobe until a new start.

Source files
------------

// File: rtl/token_slot_sched_pkg.sv
// Shared definitions for the token-ring slot timebase: scheduler states,
// ring defaults and the slot-index type shared with main_ctrl and the framers.
package token_slot_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SYNC = 2'd1,
        ST_RUN       = 2'd2
    } sched_state_t;

    localparam int DEF_MAX_ID_SLOT = 71;
    localparam int DEF_SLOT_LEN    = 500;
    localparam int DEF_GUARD       = 16;

    typedef logic [7:0] slot_idx_t;

endpackage

// File: rtl/token_slot_sched_slot_timer.sv
// Slot counter and slot index with wrap; clear, load and realign controls
// are mutually prioritised clr > load > realign > adv.
module token_slot_sched_slot_timer
    import token_slot_sched_pkg::*;
#(
    parameter int SLOT_LEN    = DEF_SLOT_LEN,
    parameter int MAX_ID_SLOT = DEF_MAX_ID_SLOT,
    parameter int CW          = $clog2(SLOT_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic [7:0]    load_id,
    input  logic          realign,
    input  logic          adv,
    output logic [CW-1:0] slot_cnt,
    output logic [7:0]    id_slot,
    output logic          last
);

    localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_LEN - 1);
    localparam slot_idx_t     ID_LAST  = slot_idx_t'(MAX_ID_SLOT);

    assign last = (slot_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_cnt <= '0;
            id_slot  <= '0;
        end else if (clr) begin
            slot_cnt <= '0;
            id_slot  <= '0;
        end else if (load) begin
            slot_cnt <= '0;
            id_slot  <= load_id;
        end else if (realign) begin
            // A sync frame marks the first clock of the slot, so we are one clock in.
            slot_cnt <= CW'(1);
        end else if (adv) begin
            if (last) begin
                slot_cnt <= '0;
                id_slot  <= (id_slot == ID_LAST) ? '0 : id_slot + 8'd1;
            end else begin
                slot_cnt <= slot_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/token_slot_sched.sv
// Token-ring slot scheduler: starts as master or joins by sync frames,
// produces the per-slot strobe/index and this board's transmit window.
module token_slot_sched
    import token_slot_sched_pkg::*;
#(
    parameter int SLOT_LEN     = DEF_SLOT_LEN,
    parameter int MAX_ID_SLOT  = DEF_MAX_ID_SLOT,
    parameter int GUARD        = DEF_GUARD,
    parameter int SYNC_TIMEOUT = 200000,
    parameter int TOL          = 8,
    parameter int MAX_ERR      = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         process_en,
    input  logic         flag_start_token,
    input  logic         join_start,
    input  logic [3:0]   slot_id,
    input  logic         rx_sync_vld,
    input  logic [7:0]   rx_sync_slot,
    output logic         flag_slot_start,
    output logic [7:0]   id_slot,
    output logic         tx_win,
    output logic         locked,
    output logic         sync_fail,
    output logic [1:0]   err_cnt,
    output sched_state_t state_dbg
);

    localparam int CW = $clog2(SLOT_LEN);
    localparam int TW = $clog2(SYNC_TIMEOUT);

    localparam logic [CW-1:0] CNT_TOL    = CW'(TOL);
    localparam logic [CW-1:0] CNT_HI_TOL = CW'(SLOT_LEN - TOL);
    localparam logic [CW-1:0] WIN_LO     = CW'(GUARD);
    localparam logic [CW-1:0] WIN_HI     = CW'(SLOT_LEN - GUARD - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(SYNC_TIMEOUT - 1);
    localparam slot_idx_t     ID_LAST    = slot_idx_t'(MAX_ID_SLOT);
    localparam logic [2:0]    ERR_LIMIT  = 3'(MAX_ERR);

    sched_state_t  state, state_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic [1:0]    err_nxt;
    logic          strobe_nxt, fail_nxt, locked_nxt, tx_nxt;

    logic          t_clr, t_load, t_realign, t_adv, t_last;
    slot_idx_t     t_load_id;
    logic [CW-1:0] slot_cnt;
    slot_idx_t     own_slot;
    logic          sync_hit;

    assign state_dbg = state;
    assign own_slot  = {4'b0, slot_id};

    // rx_sync_vld is a one-cycle valid with no back-pressure: a sync frame is
    // consumed in the cycle it is presented or not at all.
    assign sync_hit = rx_sync_vld && (rx_sync_slot == id_slot) &&
                      ((slot_cnt <= CNT_TOL) || (slot_cnt >= CNT_HI_TOL));

    token_slot_sched_slot_timer #(
        .SLOT_LEN    (SLOT_LEN),
        .MAX_ID_SLOT (MAX_ID_SLOT),
        .CW          (CW)
    ) u_slot_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (t_clr),
        .load     (t_load),
        .load_id  (t_load_id),
        .realign  (t_realign),
        .adv      (t_adv),
        .slot_cnt (slot_cnt),
        .id_slot  (id_slot),
        .last     (t_last)
    );

    always_comb begin
        state_nxt  = state;
        tcnt_nxt   = '0;
        err_nxt    = err_cnt;
        strobe_nxt = 1'b0;
        fail_nxt   = 1'b0;
        t_clr      = 1'b0;
        t_load     = 1'b0;
        t_load_id  = '0;
        t_realign  = 1'b0;
        t_adv      = 1'b0;

        if (!process_en) begin
            state_nxt = ST_IDLE;
            err_nxt   = '0;
            t_clr     = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (flag_start_token) begin
                        state_nxt  = ST_RUN;
                        t_load     = 1'b1;
                        strobe_nxt = 1'b1;
                        err_nxt    = '0;
                    end else if (join_start) begin
                        state_nxt = ST_WAIT_SYNC;
                    end
                end
                ST_WAIT_SYNC: begin
                    if (flag_start_token) begin
                        state_nxt  = ST_RUN;
                        t_load     = 1'b1;
                        strobe_nxt = 1'b1;
                        err_nxt    = '0;
                    end else if (rx_sync_vld && (rx_sync_slot <= ID_LAST)) begin
                        state_nxt  = ST_RUN;
                        t_load     = 1'b1;
                        t_load_id  = rx_sync_slot;
                        strobe_nxt = 1'b1;
                        err_nxt    = '0;
                    end else if (tcnt == TO_LAST) begin
                        state_nxt = ST_IDLE;
                        fail_nxt  = 1'b1;
                        t_clr     = 1'b1;
                    end else begin
                        tcnt_nxt = tcnt + TW'(1);
                    end
                end
                ST_RUN: begin
                    if (flag_start_token) begin
                        t_load     = 1'b1;
                        strobe_nxt = 1'b1;
                        err_nxt    = '0;
                    end else if (sync_hit) begin
                        t_realign = 1'b1;
                        err_nxt   = '0;
                    end else if (rx_sync_vld && (({1'b0, err_cnt} + 3'd1) >= ERR_LIMIT)) begin
                        // Lock is lost: freeze the timebase and hunt for a sync again.
                        state_nxt = ST_WAIT_SYNC;
                        err_nxt   = '0;
                    end else begin
                        if (rx_sync_vld) begin
                            err_nxt = (err_cnt == 2'd3) ? 2'd3 : err_cnt + 2'd1;
                        end
                        t_adv      = 1'b1;
                        strobe_nxt = t_last;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    t_clr     = 1'b1;
                end
            endcase
        end

        locked_nxt = (state_nxt == ST_RUN);
        tx_nxt     = (state == ST_RUN) && (state_nxt == ST_RUN) && (id_slot == own_slot) &&
                     (slot_cnt >= WIN_LO) && (slot_cnt <= WIN_HI);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            tcnt            <= '0;
            err_cnt         <= '0;
            flag_slot_start <= 1'b0;
            sync_fail       <= 1'b0;
            locked          <= 1'b0;
            tx_win          <= 1'b0;
        end else begin
            state           <= state_nxt;
            tcnt            <= tcnt_nxt;
            err_cnt         <= err_nxt;
            flag_slot_start <= strobe_nxt;
            sync_fail       <= fail_nxt;
            locked          <= locked_nxt;
            tx_win          <= tx_nxt;
        end
    end

endmodule

// File: tb/tb_token_slot_sched.sv
// Scoreboard bench for token_slot_sched: a behavioural ring model predicts
// every output cycle; a monitor compares the DUT against the queued predictions.
module tb_token_slot_sched;
  import token_slot_sched_pkg::*;

  localparam int SL    = 20;
  localparam int MAXID = 7;
  localparam int G     = 4;
  localparam int TO    = 50;
  localparam int TOL   = 3;
  localparam int MERR  = 3;
  localparam int W     = 14;

  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_RUN  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic process_en = 1'b0;
  logic flag_start_token = 1'b0;
  logic join_start = 1'b0;
  logic [3:0] slot_id = 4'd2;
  logic rx_sync_vld = 1'b0;
  logic [7:0] rx_sync_slot = 8'd0;

  logic flag_slot_start, tx_win, locked, sync_fail;
  logic [7:0] id_slot;
  logic [1:0] err_cnt;
  sched_state_t state_dbg;

  logic rst_drive = 1'b0;
  logic [3:0] own_drive = 4'd2;
  int n_checks = 0;
  int n_fail = 0;
  int m_mode, m_cnt, m_id, m_err, m_to;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;

  token_slot_sched #(
    .SLOT_LEN(SL), .MAX_ID_SLOT(MAXID), .GUARD(G),
    .SYNC_TIMEOUT(TO), .TOL(TOL), .MAX_ERR(MERR)
  ) dut (
    .clk(clk), .rst(rst), .process_en(process_en), .flag_start_token(flag_start_token),
    .join_start(join_start), .slot_id(slot_id), .rx_sync_vld(rx_sync_vld),
    .rx_sync_slot(rx_sync_slot), .flag_slot_start(flag_slot_start), .id_slot(id_slot),
    .tx_win(tx_win), .locked(locked), .sync_fail(sync_fail), .err_cnt(err_cnt),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (state_dbg=%0d, t=%0t)",
               name, got, want, int'(state_dbg), $time);
    end
  endtask

  // reference model
  function automatic void model_reset();
    m_mode = M_IDLE; m_cnt = 0; m_id = 0; m_err = 0; m_to = 0;
  endfunction

  function automatic void model_start(input int id);
    m_mode = M_RUN; m_cnt = 0; m_id = id; m_err = 0;
  endfunction

  task automatic model_step(input logic r, pe, st, js, sv, input logic [7:0] ss,
                            input logic [3:0] own);
    bit p_run, strobe, fail, tx;
    int p_cnt, p_id;
    p_run = (m_mode == M_RUN); p_cnt = m_cnt; p_id = m_id;
    strobe = 1'b0; fail = 1'b0;
    if (!r || !pe) begin
      model_reset();
    end else if (m_mode == M_IDLE) begin
      if (st) begin model_start(0); strobe = 1'b1; end
      else if (js) begin m_mode = M_WAIT; m_to = 0; end
    end else if (m_mode == M_WAIT) begin
      if (st) begin model_start(0); strobe = 1'b1; end
      else if (sv && int'(ss) <= MAXID) begin model_start(int'(ss)); strobe = 1'b1; end
      else if (m_to == TO - 1) begin model_reset(); fail = 1'b1; end
      else m_to++;
    end else begin
      if (st) begin
        model_start(0); strobe = 1'b1;
      end else if (sv && int'(ss) == m_id && (m_cnt <= TOL || m_cnt >= SL - TOL)) begin
        m_cnt = 1; m_err = 0;
      end else if (sv && m_err + 1 >= MERR) begin
        m_mode = M_WAIT; m_err = 0; m_to = 0;
      end else begin
        if (sv) m_err = (m_err == 3) ? 3 : m_err + 1;
        m_cnt = (m_cnt + 1) % SL;
        if (m_cnt == 0) begin m_id = (m_id + 1) % (MAXID + 1); strobe = 1'b1; end
      end
    end
    tx = r && pe && p_run && (m_mode == M_RUN) && (p_id == int'(own)) &&
         (p_cnt >= G) && (p_cnt <= SL - G - 1);
    exp_q.push_back({strobe, 8'(m_id), tx, (m_mode == M_RUN), fail, 2'(m_err)});
  endtask

  // driver tasks
  task automatic step(input logic pe, input logic st, input logic js,
                      input logic sv, input logic [7:0] ss);
    @(negedge clk);
    rst = rst_drive; process_en = pe; flag_start_token = st; join_start = js;
    rx_sync_vld = sv; rx_sync_slot = ss; slot_id = own_drive;
    model_step(rst_drive, pe, st, js, sv, ss, own_drive);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic wait_cnt(input int c);
    for (int i = 0; i < 2 * SL && !(m_mode == M_RUN && m_cnt == c); i++) idle();
  endtask

  task automatic async_reset_mid();
    @(posedge clk);
    #3;
    rst = 1'b0; rst_drive = 1'b0;
    #1;
    check("async_flag", int'(flag_slot_start), 0);
    check("async_id", int'(id_slot), 0);
    check("async_tx", int'(tx_win), 0);
    check("async_locked", int'(locked), 0);
    check("async_fail", int'(sync_fail), 0);
    check("async_err", int'(err_cnt), 0);
    model_reset();
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      check("flag_slot_start", int'(flag_slot_start), int'(mon_exp[13]));
      check("id_slot", int'(id_slot), int'(mon_exp[12:5]));
      check("tx_win", int'(tx_win), int'(mon_exp[4]));
      check("locked", int'(locked), int'(mon_exp[3]));
      check("sync_fail", int'(sync_fail), int'(mon_exp[2]));
      check("err_cnt", int'(err_cnt), int'(mon_exp[1:0]));
    end
  end

  initial begin
    model_reset();
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    rst_drive = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    repeat (2) idle();

    // master start, full ring wrap with own slot 2
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    repeat (170) idle();

    // drop process_en mid-window of own slot
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 200 && !(m_mode == M_RUN && m_id == 2 && m_cnt == 8); i++) idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    idle();

    // join: out-of-range sync ignored, then lock to slot 5
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'd200);
    repeat (3) idle();
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'd5);
    repeat (30) idle();

    // realign late (SL-3) and early (TOL)
    wait_cnt(SL - 3);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'(m_id));
    repeat (45) idle();
    wait_cnt(TOL);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'(m_id));
    repeat (10) idle();

    // three mismatches drop lock, then the hunt times out
    for (int k = 0; k < 3; k++) begin
      repeat (5) idle();
      step(1'b1, 1'b0, 1'b0, 1'b1, 8'((m_id + 1) % (MAXID + 1)));
    end
    repeat (TO + 5) idle();

    // master start wins over a same-cycle sync in WAIT_SYNC
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'd5);
    repeat (25) idle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic pe, st, js, sv;
      logic [7:0] ss;
      pe = ($urandom_range(0, 99) != 0);
      st = ($urandom_range(0, 299) == 0);
      js = ($urandom_range(0, 19) == 0);
      sv = ($urandom_range(0, 11) == 0);
      if (m_mode == M_RUN && (m_cnt <= TOL + 1 || m_cnt >= SL - TOL - 1) &&
          $urandom_range(0, 3) == 0) begin
        sv = 1'b1;
        ss = 8'(m_id);
      end else begin
        case ($urandom_range(0, 2))
          0: ss = 8'(m_id);
          1: ss = 8'($urandom_range(0, MAXID));
          default: ss = 8'($urandom_range(0, 255));
        endcase
      end
      if ($urandom_range(0, 499) == 0) own_drive = 4'($urandom_range(0, 15));
      step(pe, st, js, sv, ss);
    end

    // async reset between edges while running
    own_drive = 4'd2;
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    repeat (30) idle();
    async_reset_mid();
    repeat (3) idle();
    rst_drive = 1'b1;
    repeat (10) idle();

    repeat (3) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
